stream_arbiter_mux: RTL

// - N-channel registered arbitrating multiplexer; successor to the fixed 8:1 combinational mux.
// - Selects one of CHANNELS valid/ready input streams per cycle, using round-robin or fixed priority.
// - Registers the winner into a single output stage with a valid/ready handshake.
// - Sits between multiple requesters (fetch, load/store, debug) and a shared downstream port.
//

---
 rtl/stream_arbiter_mux_if.sv | 26 ++
 rtl/stream_arbiter_mux.sv | 81 ++++++++
 2 files changed

// File: rtl/stream_arbiter_mux_if.sv
// rtl/stream_arbiter_mux_if.sv - request/response bundle between requesters, arbiter and downstream port
// slave is the arbiter's view; master is the view of whoever drives requests and drains beats.
interface stream_arbiter_mux_if #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 8
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_sel;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/stream_arbiter_mux.sv
// rtl/stream_arbiter_mux.sv - registered N-channel arbitrating stream mux
// One output register; round-robin (RR_MODE=1) or lowest-index-wins (RR_MODE=0) grant.
module stream_arbiter_mux #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 8,
  parameter int RR_MODE  = 1
) (
  input logic                 clock,
  input logic                 reset_n,
  stream_arbiter_mux_if.slave bus
);
  localparam int SEL_W = $clog2(CHANNELS);

  generate
    if (CHANNELS < 2 || CHANNELS > 32) begin : g_bad_channels
      $error("stream_arbiter_mux: CHANNELS must be in 2..32");
    end
  endgenerate

  logic [SEL_W-1:0]    rr_ptr;
  logic [CHANNELS-1:0] grant;
  logic [SEL_W-1:0]    grant_idx;
  logic                grant_any;
  logic [WIDTH-1:0]    grant_data;
  logic                load;
  logic                out_valid_q;
  logic [WIDTH-1:0]    out_data_q;
  logic [SEL_W-1:0]    out_sel_q;

  assign load = !out_valid_q || bus.out_ready;

  // Scan starts at rr_ptr in round-robin mode, at 0 in fixed-priority mode; first valid wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    grant     = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = (RR_MODE != 0) ? int'(rr_ptr) + k : k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!grant_any && bus.in_valid[SEL_W'(idx)]) begin
        grant_any = 1'b1;
        grant_idx = SEL_W'(idx);
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant[i]) grant_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  // Gated by reset_n so no upstream beat is accepted while the stage is being cleared.
  assign bus.in_ready = (load && reset_n) ? grant : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      rr_ptr      <= '0;
    end else if (load) begin
      out_valid_q <= grant_any;
      if (grant_any) begin
        out_data_q <= grant_data;
        out_sel_q  <= grant_idx;
        if (RR_MODE != 0) begin
          rr_ptr <= (grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx + SEL_W'(1);
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
endmodule
